// File: rtl/range_tracker.sv
// range_tracker: session-based streaming min/max/range/count statistics.
//
// A session opens on go and closes on finish. Each qualified sample
// (valid_in) inside the session updates a running max, min and a saturating
// count. On a clean finish the results are latched into the output registers
// and done pulses for one cycle. Protocol misuse raises the sticky
// debug_error flag, which is cleared by the next accepted go from IDLE.
//
// Parameters:
//   WIDTH  - sample width in bits (>=2)
//   SIGNED - 0: unsigned ordering, 1: two's complement ordering
//   CNT_W  - accepted-sample counter width (>=1)
//
// Ports:
//   clock       in   rising-edge clock
//   reset       in   asynchronous, active-high reset
//   data_in     in   [WIDTH]  sample value
//   valid_in    in   data_in carries a sample this cycle
//   go          in   start-session strobe
//   finish      in   end-session strobe
//   max_out     out  [WIDTH]  maximum of the last completed session
//   min_out     out  [WIDTH]  minimum of the last completed session
//   range       out  [WIDTH]  max_out - min_out
//   count       out  [CNT_W]  samples accepted, saturating
//   done        out  one-cycle pulse when results update
//   busy        out  session in progress
//   debug_error out  sticky protocol-error flag
//   sum_out     out  [WIDTH+CNT_W] session sum (only with RANGE_TRACKER_SUM_EN)
//
// Optional feature macro: RANGE_TRACKER_SUM_EN adds the sum accumulator and
// the sum_out port.
//
// state | meaning
// ------+-------------------------------------------
// IDLE  | no session open; outputs hold last results
// BUSY  | session open; samples are accumulated

module range_tracker #(
  parameter int WIDTH  = 16,
  parameter int SIGNED = 0,
  parameter int CNT_W  = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             valid_in,
  input  logic             go,
  input  logic             finish,
  output logic [WIDTH-1:0] max_out,
  output logic [WIDTH-1:0] min_out,
  output logic [WIDTH-1:0] range,
  output logic [CNT_W-1:0] count,
  output logic             done,
  output logic             busy,
  output logic             debug_error
`ifdef RANGE_TRACKER_SUM_EN
  ,
  output logic [WIDTH+CNT_W-1:0] sum_out
`endif
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] run_max_q, run_max_d;
  logic [WIDTH-1:0] run_min_q, run_min_d;
  logic [CNT_W-1:0] run_cnt_q, run_cnt_d;
  logic [WIDTH-1:0] max_out_q, max_out_d;
  logic [WIDTH-1:0] min_out_q, min_out_d;
  logic [WIDTH-1:0] range_q, range_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  // Base values the current sample is folded into, and the folded result.
  logic [WIDTH-1:0] base_max, base_min, nxt_max, nxt_min;
  logic [CNT_W-1:0] base_cnt, nxt_cnt;

  logic start, abort, take;

`ifdef RANGE_TRACKER_SUM_EN
  logic [WIDTH+CNT_W-1:0] run_sum_q, run_sum_d;
  logic [WIDTH+CNT_W-1:0] sum_out_q, sum_out_d;
  logic [WIDTH+CNT_W-1:0] base_sum, nxt_sum, data_ext;

  assign data_ext = (SIGNED != 0) ? {{CNT_W{data_in[WIDTH-1]}}, data_in}
                                  : {{CNT_W{1'b0}}, data_in};
`endif

  function automatic logic greater(input logic [WIDTH-1:0] a,
                                   input logic [WIDTH-1:0] b);
    if (SIGNED != 0) return $signed(a) > $signed(b);
    else             return a > b;
  endfunction

  // go wins a restart only without finish; go together with finish aborts.
  assign start = go & ~finish;
  assign abort = go & finish;
  assign take  = valid_in & ~abort & (start | (state_q == BUSY));

  always_comb begin
    // A (re)start clears the running values first so a same-cycle sample
    // becomes the first sample of the new session.
    if (start) begin
      base_max = '0;
      base_min = '0;
      base_cnt = '0;
    end else begin
      base_max = run_max_q;
      base_min = run_min_q;
      base_cnt = run_cnt_q;
    end
    nxt_max = base_max;
    nxt_min = base_min;
    nxt_cnt = base_cnt;
    if (take) begin
      if (base_cnt == '0) begin
        nxt_max = data_in;
        nxt_min = data_in;
      end else begin
        if (greater(data_in, base_max)) nxt_max = data_in;
        if (greater(base_min, data_in)) nxt_min = data_in;
      end
      if (base_cnt != CNT_MAX) nxt_cnt = base_cnt + CNT_W'(1);
    end
  end

`ifdef RANGE_TRACKER_SUM_EN
  always_comb begin
    base_sum = start ? '0 : run_sum_q;
    nxt_sum  = take ? (base_sum + data_ext) : base_sum;
  end
`endif

  always_comb begin
    state_d   = state_q;
    run_max_d = run_max_q;
    run_min_d = run_min_q;
    run_cnt_d = run_cnt_q;
    max_out_d = max_out_q;
    min_out_d = min_out_q;
    range_d   = range_q;
    count_d   = count_q;
    done_d    = 1'b0;
    err_d     = err_q;
`ifdef RANGE_TRACKER_SUM_EN
    run_sum_d = run_sum_q;
    sum_out_d = sum_out_q;
`endif
    if (abort) begin
      state_d   = IDLE;
      err_d     = 1'b1;
      run_max_d = '0;
      run_min_d = '0;
      run_cnt_d = '0;
`ifdef RANGE_TRACKER_SUM_EN
      run_sum_d = '0;
`endif
    end else if (start) begin
      // Restart from BUSY is an error; a go from IDLE clears the flag.
      state_d   = BUSY;
      err_d     = (state_q == BUSY);
      run_max_d = nxt_max;
      run_min_d = nxt_min;
      run_cnt_d = nxt_cnt;
`ifdef RANGE_TRACKER_SUM_EN
      run_sum_d = nxt_sum;
`endif
    end else if (finish) begin
      if (state_q == BUSY) begin
        state_d   = IDLE;
        done_d    = 1'b1;
        run_max_d = nxt_max;
        run_min_d = nxt_min;
        run_cnt_d = nxt_cnt;
        max_out_d = nxt_max;
        min_out_d = nxt_min;
        range_d   = nxt_max - nxt_min;
        count_d   = nxt_cnt;
`ifdef RANGE_TRACKER_SUM_EN
        run_sum_d = nxt_sum;
        sum_out_d = nxt_sum;
`endif
      end else begin
        err_d = 1'b1;
      end
    end else if (state_q == BUSY) begin
      run_max_d = nxt_max;
      run_min_d = nxt_min;
      run_cnt_d = nxt_cnt;
`ifdef RANGE_TRACKER_SUM_EN
      run_sum_d = nxt_sum;
`endif
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      run_max_q <= '0;
      run_min_q <= '0;
      run_cnt_q <= '0;
      max_out_q <= '0;
      min_out_q <= '0;
      range_q   <= '0;
      count_q   <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      run_max_q <= run_max_d;
      run_min_q <= run_min_d;
      run_cnt_q <= run_cnt_d;
      max_out_q <= max_out_d;
      min_out_q <= min_out_d;
      range_q   <= range_d;
      count_q   <= count_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

`ifdef RANGE_TRACKER_SUM_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      run_sum_q <= '0;
      sum_out_q <= '0;
    end else begin
      run_sum_q <= run_sum_d;
      sum_out_q <= sum_out_d;
    end
  end

  assign sum_out = sum_out_q;
`endif

  assign max_out     = max_out_q;
  assign min_out     = min_out_q;
  assign range       = range_q;
  assign count       = count_q;
  assign done        = done_q;
  assign busy        = (state_q == BUSY);
  assign debug_error = err_q;

endmodule

// File: tb/tb_range_tracker.sv
// Directed bench for range_tracker: a 16-bit unsigned instance driven from a
// vector table, plus signed 8-bit and CNT_W=2 instances and a mid-session
// reset sequence.
module tb_range_tracker;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_err = 0;

  // 16-bit unsigned, CNT_W=8
  logic [15:0] m_d = '0;
  logic        m_vld = 0, m_go = 0, m_fin = 0;
  logic [15:0] m_max, m_min, m_rng;
  logic [7:0]  m_cnt;
  logic        m_done, m_busy, m_err;
`ifdef RANGE_TRACKER_SUM_EN
  logic [23:0] m_sum;
`endif

  range_tracker #(.WIDTH(16), .SIGNED(0), .CNT_W(8)) u_m (
    .clock(clock), .reset(reset), .data_in(m_d), .valid_in(m_vld),
    .go(m_go), .finish(m_fin), .max_out(m_max), .min_out(m_min),
    .range(m_rng), .count(m_cnt), .done(m_done), .busy(m_busy),
    .debug_error(m_err)
`ifdef RANGE_TRACKER_SUM_EN
    , .sum_out(m_sum)
`endif
  );

  // 8-bit signed, CNT_W=8
  logic [7:0] s_d = '0;
  logic       s_vld = 0, s_go = 0, s_fin = 0;
  logic [7:0] s_max, s_min, s_rng, s_cnt;
  logic       s_done, s_busy, s_err;
`ifdef RANGE_TRACKER_SUM_EN
  logic [15:0] s_sum;
`endif

  range_tracker #(.WIDTH(8), .SIGNED(1), .CNT_W(8)) u_s (
    .clock(clock), .reset(reset), .data_in(s_d), .valid_in(s_vld),
    .go(s_go), .finish(s_fin), .max_out(s_max), .min_out(s_min),
    .range(s_rng), .count(s_cnt), .done(s_done), .busy(s_busy),
    .debug_error(s_err)
`ifdef RANGE_TRACKER_SUM_EN
    , .sum_out(s_sum)
`endif
  );

  // 8-bit unsigned, CNT_W=2 (saturates at 3)
  logic [7:0] c_d = '0;
  logic       c_vld = 0, c_go = 0, c_fin = 0;
  logic [7:0] c_max, c_min, c_rng;
  logic [1:0] c_cnt;
  logic       c_done, c_busy, c_err;
`ifdef RANGE_TRACKER_SUM_EN
  logic [9:0] c_sum;
`endif

  range_tracker #(.WIDTH(8), .SIGNED(0), .CNT_W(2)) u_c (
    .clock(clock), .reset(reset), .data_in(c_d), .valid_in(c_vld),
    .go(c_go), .finish(c_fin), .max_out(c_max), .min_out(c_min),
    .range(c_rng), .count(c_cnt), .done(c_done), .busy(c_busy),
    .debug_error(c_err)
`ifdef RANGE_TRACKER_SUM_EN
    , .sum_out(c_sum)
`endif
  );

  typedef struct {
    logic        go, fin, vld;
    logic [15:0] d;
    logic        e_done, e_busy, e_err;
    logic [15:0] e_max, e_min, e_rng;
    logic [7:0]  e_cnt;
  } vec_t;

  localparam int NV = 27;
  vec_t v [NV];

  function automatic vec_t mk(input logic g, f, vl, input logic [15:0] d,
                              input logic dn, b, e,
                              input logic [15:0] mx, mn, rg,
                              input logic [7:0] ct);
    vec_t r;
    r.go = g; r.fin = f; r.vld = vl; r.d = d;
    r.e_done = dn; r.e_busy = b; r.e_err = e;
    r.e_max = mx; r.e_min = mn; r.e_rng = rg; r.e_cnt = ct;
    return r;
  endfunction

  task automatic chk(input string nm, input int idx,
                     input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s[%0d]: got %0h expected %0h", nm, idx, act, exp);
    end
  endtask

  task automatic chk_m(input int i, input logic dn, b, e,
                       input logic [15:0] mx, mn, rg, input logic [7:0] ct);
    chk("m_done", i, 32'(m_done), 32'(dn));
    chk("m_busy", i, 32'(m_busy), 32'(b));
    chk("m_err",  i, 32'(m_err),  32'(e));
    chk("m_max",  i, 32'(m_max),  32'(mx));
    chk("m_min",  i, 32'(m_min),  32'(mn));
    chk("m_range",i, 32'(m_rng),  32'(rg));
    chk("m_count",i, 32'(m_cnt),  32'(ct));
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    //        go fin vld data     done busy err  max      min      range    cnt
    v[0]  = mk(0, 0, 0, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 8'd0);
    v[1]  = mk(1, 0, 1, 16'h0010, 0, 1, 0, 16'h0000, 16'h0000, 16'h0000, 8'd0);
    v[2]  = mk(0, 0, 1, 16'h0005, 0, 1, 0, 16'h0000, 16'h0000, 16'h0000, 8'd0);
    v[3]  = mk(0, 0, 1, 16'h00F0, 0, 1, 0, 16'h0000, 16'h0000, 16'h0000, 8'd0);
    v[4]  = mk(0, 1, 0, 16'h0000, 1, 0, 0, 16'h00F0, 16'h0005, 16'h00EB, 8'd3);
    v[5]  = mk(0, 0, 0, 16'h0000, 0, 0, 0, 16'h00F0, 16'h0005, 16'h00EB, 8'd3);
    v[6]  = mk(0, 0, 1, 16'hFFFF, 0, 0, 0, 16'h00F0, 16'h0005, 16'h00EB, 8'd3);
    v[7]  = mk(0, 1, 0, 16'h0000, 0, 0, 1, 16'h00F0, 16'h0005, 16'h00EB, 8'd3);
    v[8]  = mk(1, 0, 0, 16'h0000, 0, 1, 0, 16'h00F0, 16'h0005, 16'h00EB, 8'd3);
    v[9]  = mk(0, 0, 1, 16'h0022, 0, 1, 0, 16'h00F0, 16'h0005, 16'h00EB, 8'd3);
    v[10] = mk(0, 1, 0, 16'h0000, 1, 0, 0, 16'h0022, 16'h0022, 16'h0000, 8'd1);
    v[11] = mk(1, 0, 0, 16'h0000, 0, 1, 0, 16'h0022, 16'h0022, 16'h0000, 8'd1);
    v[12] = mk(0, 0, 1, 16'h0001, 0, 1, 0, 16'h0022, 16'h0022, 16'h0000, 8'd1);
    v[13] = mk(0, 0, 1, 16'h0009, 0, 1, 0, 16'h0022, 16'h0022, 16'h0000, 8'd1);
    v[14] = mk(1, 0, 0, 16'h0000, 0, 1, 1, 16'h0022, 16'h0022, 16'h0000, 8'd1);
    v[15] = mk(0, 0, 1, 16'h0004, 0, 1, 1, 16'h0022, 16'h0022, 16'h0000, 8'd1);
    v[16] = mk(0, 1, 0, 16'h0000, 1, 0, 1, 16'h0004, 16'h0004, 16'h0000, 8'd1);
    v[17] = mk(1, 0, 0, 16'h0000, 0, 1, 0, 16'h0004, 16'h0004, 16'h0000, 8'd1);
    v[18] = mk(0, 0, 1, 16'h0030, 0, 1, 0, 16'h0004, 16'h0004, 16'h0000, 8'd1);
    v[19] = mk(1, 1, 0, 16'h0000, 0, 0, 1, 16'h0004, 16'h0004, 16'h0000, 8'd1);
    v[20] = mk(0, 0, 0, 16'h0000, 0, 0, 1, 16'h0004, 16'h0004, 16'h0000, 8'd1);
    v[21] = mk(1, 0, 0, 16'h0000, 0, 1, 0, 16'h0004, 16'h0004, 16'h0000, 8'd1);
    v[22] = mk(0, 1, 0, 16'h0000, 1, 0, 0, 16'h0000, 16'h0000, 16'h0000, 8'd0);
    v[23] = mk(1, 1, 1, 16'h0055, 0, 0, 1, 16'h0000, 16'h0000, 16'h0000, 8'd0);
    v[24] = mk(1, 0, 1, 16'h0100, 0, 1, 0, 16'h0000, 16'h0000, 16'h0000, 8'd0);
    v[25] = mk(0, 1, 1, 16'h0200, 1, 0, 0, 16'h0200, 16'h0100, 16'h0100, 8'd2);
    v[26] = mk(0, 0, 0, 16'h0000, 0, 0, 0, 16'h0200, 16'h0100, 16'h0100, 8'd2);

    // Reset state
    repeat (2) @(posedge clock);
    #1;
    chk_m(-1, 0, 0, 0, 16'h0, 16'h0, 16'h0, 8'd0);
    @(negedge clock);
    reset = 1'b0;

    for (int i = 0; i < NV; i++) begin
      @(negedge clock);
      m_go = v[i].go; m_fin = v[i].fin; m_vld = v[i].vld; m_d = v[i].d;
      tick();
      chk_m(i, v[i].e_done, v[i].e_busy, v[i].e_err,
            v[i].e_max, v[i].e_min, v[i].e_rng, v[i].e_cnt);
    end
    @(negedge clock);
    m_go = 0; m_fin = 0; m_vld = 0; m_d = '0;
`ifdef RANGE_TRACKER_SUM_EN
    chk("m_sum", 0, 32'(m_sum), 32'h300);
`endif

    // Signed and saturating instances side by side
    @(negedge clock);
    s_go = 1; s_vld = 1; s_d = 8'h7F;  c_go = 1; c_vld = 1; c_d = 8'd3;
    tick();
    chk("s_busy", 0, 32'(s_busy), 32'd1);
    @(negedge clock);
    s_go = 0; s_d = 8'h80;  c_go = 0; c_d = 8'd1;
    tick();
    @(negedge clock);
    s_d = 8'h00;  c_d = 8'd7;
    tick();
    @(negedge clock);
    s_fin = 1; s_vld = 0;  c_d = 8'd2;
    tick();
    chk("s_done",  0, 32'(s_done), 32'd1);
    chk("s_max",   0, 32'(s_max),  32'h7F);
    chk("s_min",   0, 32'(s_min),  32'h80);
    chk("s_range", 0, 32'(s_rng),  32'hFF);
    chk("s_count", 0, 32'(s_cnt),  32'd3);
    chk("s_err",   0, 32'(s_err),  32'd0);
`ifdef RANGE_TRACKER_SUM_EN
    chk("s_sum",   0, 32'(s_sum),  32'hFFFF);
`endif
    chk("c_done_early", 0, 32'(c_done), 32'd0);
    @(negedge clock);
    s_fin = 0;  c_d = 8'd5;
    tick();
    chk("s_done_drop", 0, 32'(s_done), 32'd0);
    @(negedge clock);
    c_fin = 1; c_vld = 0;
    tick();
    chk("c_done",  0, 32'(c_done), 32'd1);
    chk("c_count", 0, 32'(c_cnt),  32'd3);
    chk("c_max",   0, 32'(c_max),  32'd7);
    chk("c_min",   0, 32'(c_min),  32'd1);
    chk("c_range", 0, 32'(c_rng),  32'd6);
`ifdef RANGE_TRACKER_SUM_EN
    chk("c_sum",   0, 32'(c_sum),  32'd18);
`endif
    @(negedge clock);
    c_fin = 0;

    // Mid-session asynchronous reset
    @(negedge clock);
    m_go = 1; m_vld = 1; m_d = 16'h1234;
    tick();
    chk("rst_pre_busy", 0, 32'(m_busy), 32'd1);
    @(negedge clock);
    m_go = 0; m_vld = 1; m_d = 16'h0001;
    #2 reset = 1'b1;
    #1;
    chk_m(100, 0, 0, 0, 16'h0, 16'h0, 16'h0, 8'd0);
    reset = 1'b0;
    @(negedge clock);
    m_vld = 0; m_fin = 1;
    tick();
    chk_m(101, 0, 0, 1, 16'h0, 16'h0, 16'h0, 8'd0);
    @(negedge clock);
    m_fin = 0;
    tick();
    chk("rst_post_done", 0, 32'(m_done), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
